// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8N1 serializer.
// Bytes written by the core are queued and sent LSB-first as
// start(0) + 8 data + stop(1) frames. Each bit lasts CLK_DIV clocks.
//
// Write handshake: wr_Sig is a valid strobe and the implicit ready is !full.
// A byte transfers on any clk edge where wr_Sig=1 and full=0 (full as seen
// before that edge). wr_Sig=1 while full=1 drops the byte and raises
// overflow for that single cycle.
//
// fsm_State exposes the serializer state: 0=IDLE 1=START 2=DATA 3=STOP.
module uart_tx_buffered #(
  parameter int CLK_DIV = 5208,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_Sig,
  input  logic [7:0]        wr_Data,
  input  logic              tx_En,
  output logic              tx,
  output logic              busy,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [1:0]        fsm_State
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [15:0]     BAUD_LAST = 16'(CLK_DIV - 1);

  // FIFO storage and bookkeeping
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              push;
  logic              pop;

  // Serializer
  state_t            state;
  logic [15:0]       baud_cnt;
  logic              baud_wrap;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              line_bit;

  assign push      = wr_Sig & ~full;
  assign baud_wrap = (baud_cnt == BAUD_LAST);
  // Pop only from IDLE or on the final STOP cycle; empty gates it so an
  // empty FIFO can never be read.
  assign pop       = ~empty & tx_En &
                     ((state == IDLE) | ((state == STOP) & baud_wrap));
  assign fsm_State = state;

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (ADDR_W+1)'(1);
      2'b01:   count_nxt = count - (ADDR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Line level for the current state; registered into tx one cycle later.
  always_comb begin
    line_bit = 1'b1;
    case (state)
      IDLE:    line_bit = 1'b1;
      START:   line_bit = 1'b0;
      DATA:    line_bit = shift[0];
      STOP:    line_bit = 1'b1;
      default: line_bit = 1'b1;
    endcase
  end

  // FIFO data array; contents are don't-care once pointers are reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_Data;
  end

  // FIFO pointers, occupancy flags and overflow pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count    <= count_nxt;
      full     <= (count_nxt == DEPTH_L);
      empty    <= (count_nxt == '0);
      overflow <= wr_Sig & full;
    end
  end

  // Frame sequencer: walks START/DATA/STOP on baud wraps, drives tx and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      tx   <= line_bit;
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            // Back-to-back: next frame starts with no idle cycle.
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at CLK_DIV=4 (40-cycle frames).
module tb_uart_tx_buffered;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              wr_Sig = 1'b0;
  logic [7:0]        wr_Data = 8'h00;
  logic              tx_En = 1'b0;
  logic              tx;
  logic              busy;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [1:0]        fsm_State;

  uart_tx_buffered #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .wr_Sig(wr_Sig), .wr_Data(wr_Data),
    .tx_En(tx_En), .tx(tx), .busy(busy), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .fsm_State(fsm_State)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs/outputs are touched 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receive one frame from tx by mid-bit sampling. ok=0 on timeout or bad framing.
  task automatic recv_frame(output logic [7:0] d, output int t0, output bit ok);
    int w;
    ok = 1'b1; d = 8'h00; t0 = 0; w = 0;
    while (tx !== 1'b0 && w < 400) begin tick(); w++; end
    if (tx !== 1'b0) begin ok = 1'b0; return; end
    t0 = cyc;
    repeat (2) tick();
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (4) tick();
      d[i] = tx;
    end
    repeat (4) tick();
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_vec++; if (tx !== 1'b1)       begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_vec++; if (empty !== 1'b1)    begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_vec++; if (count !== 5'd0)    begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_vec++; if (full !== 1'b0)     begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_byte();
    // 0x93 LSB first framed: 0,1,1,0,0,1,0,0,1,1 (bit c of pat is slot c)
    logic [9:0] pat;
    pat = 10'b1100100110;
    tx_En = 1'b1; wr_Sig = 1'b1; wr_Data = 8'h93;
    tick();
    wr_Sig = 1'b0;
    n_vec++; if (count !== 5'd1) begin n_err++; $display("FAIL single_count_after_write: got %0d want 1", count); end
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty_after_write: got %b want 0", empty); end
    tick();
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL single_count_after_pop: got %0d want 0", count); end
    n_vec++; if (tx !== 1'b1)    begin n_err++; $display("FAIL single_tx_before_fall: got %b want 1", tx); end
    for (int c = 0; c < 40; c++) begin
      tick();
      n_vec++;
      if (tx !== pat[c/4]) begin n_err++; $display("FAIL single_line cycle %0d: got %b want %b", c, tx, pat[c/4]); end
      if (c == 0) begin
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_start: got %b want 1", busy); end
      end
    end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_vec++; if (tx !== 1'b1)   begin n_err++; $display("FAIL single_tx_idle: got %b want 1", tx); end
    tx_En = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h11 * (i + 1)));
    tx_En = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          wr_Sig = 1'b1; wr_Data = 8'(8'h11 * (i + 1));
          tick();
        end
        wr_Sig = 1'b0;
      end
      begin
        logic [7:0] d; int t0; int tprev; bit ok; logic [7:0] e;
        tprev = 0;
        for (int k = 0; k < 8; k++) begin
          recv_frame(d, t0, ok);
          e = exp_q.pop_front();
          n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL burst_frame %0d: got ok=%b want 1", k, ok); end
          n_vec++; if (d !== e)     begin n_err++; $display("FAIL burst_data %0d: got %h want %h", k, d, e); end
          if (k > 0) begin
            n_vec++; if (t0 - tprev != 40) begin n_err++; $display("FAIL burst_gap %0d: got %0d want 40", k, t0 - tprev); end
          end
          tprev = t0;
        end
      end
    join
    tx_En = 1'b0;
    repeat (4) tick();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL burst_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] d; int t0; bit ok; logic [7:0] e;
    tx_En = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_Sig = 1'b1; wr_Data = 8'(8'hA0 + i);
      if (i < 16) exp_q.push_back(8'(8'hA0 + i));
      tick();
      if (i == 14) begin
        n_vec++; if (full !== 1'b0)   begin n_err++; $display("FAIL ovf_full_at15: got %b want 0", full); end
        n_vec++; if (count !== 5'd15) begin n_err++; $display("FAIL ovf_count_at15: got %0d want 15", count); end
      end
      if (i == 15) begin
        n_vec++; if (full !== 1'b1)     begin n_err++; $display("FAIL ovf_full_at16: got %b want 1", full); end
        n_vec++; if (count !== 5'd16)   begin n_err++; $display("FAIL ovf_count_at16: got %0d want 16", count); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early_pulse: got %b want 0", overflow); end
      end
      if (i == 16) begin
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
        n_vec++; if (count !== 5'd16)   begin n_err++; $display("FAIL ovf_count_kept: got %0d want 16", count); end
      end
    end
    wr_Sig = 1'b0;
    tick();
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pulse_width: got %b want 0", overflow); end
    tx_En = 1'b1;
    for (int k = 0; k < 16; k++) begin
      recv_frame(d, t0, ok);
      e = exp_q.pop_front();
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL ovf_frame %0d: got ok=%b want 1", k, ok); end
      n_vec++; if (d !== e)     begin n_err++; $display("FAIL ovf_data %0d: got %h want %h", k, d, e); end
    end
    tx_En = 1'b0;
    repeat (4) tick();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hC1 + i));
    exp_q.push_back(8'hE5);
    tx_En = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          wr_Sig = 1'b1; wr_Data = 8'(8'hC1 + i);
          tick();
        end
        wr_Sig = 1'b0;
        n_vec++; if (count !== 5'd4) begin n_err++; $display("FAIL pp_count_loaded: got %0d want 4", count); end
        tx_En = 1'b1;
        tick();
        n_vec++; if (count !== 5'd3) begin n_err++; $display("FAIL pp_count_first_pop: got %0d want 3", count); end
        repeat (39) tick();
        n_vec++; if (fsm_State !== 2'd3) begin n_err++; $display("FAIL pp_state_stop: got %0d want 3", fsm_State); end
        wr_Sig = 1'b1; wr_Data = 8'hE5;
        tick();
        wr_Sig = 1'b0;
        n_vec++; if (count !== 5'd3)     begin n_err++; $display("FAIL pp_count_same_edge: got %0d want 3", count); end
        n_vec++; if (fsm_State !== 2'd1) begin n_err++; $display("FAIL pp_state_start: got %0d want 1", fsm_State); end
      end
      begin
        logic [7:0] d; int t0; bit ok; logic [7:0] e;
        for (int k = 0; k < 5; k++) begin
          recv_frame(d, t0, ok);
          e = exp_q.pop_front();
          n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL pp_frame %0d: got ok=%b want 1", k, ok); end
          n_vec++; if (d !== e)     begin n_err++; $display("FAIL pp_data %0d: got %h want %h", k, d, e); end
        end
      end
    join
    tx_En = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_abort();
    logic [7:0] d; int t0; bit ok; logic [7:0] e; bit saw_low;
    tx_En = 1'b1;
    wr_Sig = 1'b1; wr_Data = 8'h0F;
    tick();
    wr_Data = 8'h3C;
    tick();
    wr_Sig = 1'b0;
    repeat (22) tick();
    // Now inside data bit 4 of 0x0F (a 0 bit)
    n_vec++; if (tx !== 1'b0)        begin n_err++; $display("FAIL abort_mid_bit4: got %b want 0", tx); end
    n_vec++; if (fsm_State !== 2'd2) begin n_err++; $display("FAIL abort_state_data: got %0d want 2", fsm_State); end
    reset = 1'b1;
    tick();
    n_vec++; if (tx !== 1'b1)        begin n_err++; $display("FAIL abort_tx: got %b want 1", tx); end
    n_vec++; if (empty !== 1'b1)     begin n_err++; $display("FAIL abort_empty: got %b want 1", empty); end
    n_vec++; if (count !== 5'd0)     begin n_err++; $display("FAIL abort_count: got %0d want 0", count); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_vec++; if (fsm_State !== 2'd0) begin n_err++; $display("FAIL abort_state: got %0d want 0", fsm_State); end
    reset = 1'b0;
    saw_low = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    n_vec++; if (saw_low !== 1'b0) begin n_err++; $display("FAIL abort_line_quiet: got low=%b want 0", saw_low); end
    exp_q.push_back(8'hC3);
    wr_Sig = 1'b1; wr_Data = 8'hC3;
    tick();
    wr_Sig = 1'b0;
    recv_frame(d, t0, ok);
    e = exp_q.pop_front();
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL abort_new_frame: got ok=%b want 1", ok); end
    n_vec++; if (d !== e)     begin n_err++; $display("FAIL abort_new_data: got %h want %h", d, e); end
    tx_En = 1'b0;
    repeat (4) tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_push_pop();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
